// File: rtl/line_mem_responder_pkg.sv
// mem_if_pkg: shared line-memory widths and responder state encoding.
package mem_if_pkg;
    localparam int LINE_W        = 256;
    localparam int LINE_OFFSET_W = 5;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} mem_state_e;
endpackage

// File: rtl/line_mem_responder_if.sv
// line_mem_responder_if: cache-to-memory line request/ack bus.
interface line_mem_responder_if
    import mem_if_pkg::*;
#(
    parameter int DATA_W = LINE_W,
    parameter int ADDR_W = 32
) ();
    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] data_i;
    logic              ack_o;
    logic [DATA_W-1:0] data_o;
    modport master (output enable_i, write_i, addr_i, data_i, input ack_o, data_o);
    modport slave  (input enable_i, write_i, addr_i, data_i, output ack_o, data_o);
endinterface

// File: rtl/line_mem_responder_sram.sv
// line_sram: line array with synchronous write and registered, resettable read.
module line_sram
    import mem_if_pkg::*;
#(
    parameter int DATA_W = LINE_W,
    parameter int DEPTH  = 512
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        data_o
);
    logic [DATA_W-1:0] memory [DEPTH];
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk_i) begin
        if (we_i) memory[addr_i] <= data_i;
    end

    always_comb data_d = re_i ? memory[addr_i] : data_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data_o = data_q;
endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency line memory model answering one request at a time.
module line_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = LINE_W,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    line_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    mem_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_en, wr_en, capture;
    logic              unused_addr;

    assign unused_addr = ^{bus.addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W], bus.addr_i[LINE_OFFSET_W-1:0]};
    assign capture     = state_q == IDLE && bus.enable_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable_i) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    // Counter parks at 0 outside WAIT so it can never wrap.
    always_comb begin
        cnt_d   = capture ? 8'(LATENCY - 1) : (state_q == WAIT && cnt_q != '0) ? cnt_q - 8'd1 : cnt_q;
        idx_d   = capture ? bus.addr_i[LINE_OFFSET_W +: IDX_W] : idx_q;
        wr_d    = capture ? bus.write_i : wr_q;
        wdata_d = capture ? bus.data_i : wdata_q;
    end

    always_comb begin
        bus.ack_o = state_q == ACK;
        rd_en     = state_q == WAIT && cnt_q == '0 && !wr_q;
        wr_en     = state_q == ACK && wr_q;
    end

    line_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_sram (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (wr_en),
        .re_i   (rd_en),
        .addr_i (idx_q),
        .data_i (wdata_q),
        .data_o (bus.data_o)
    );
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed checks on a LATENCY=10 and a LATENCY=1 responder.
module tb_line_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_mem_responder_if ifa ();
    line_mem_responder_if ifb ();

    line_mem_responder #(.LATENCY(10)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(ifa));
    line_mem_responder #(.LATENCY(1))  dut_b (.clk_i(clk), .rst_i(rst_n), .bus(ifb));

    // Issue one request on dut_a from a negedge; returns at the negedge after ack.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [255:0] data,
                          input int drop_at, output int lat, output int ack_cyc,
                          output logic [255:0] rd, output logic ack_next);
        int start;
        ifa.enable_i = 1'b1;
        ifa.write_i  = wr;
        ifa.addr_i   = addr;
        ifa.data_i   = data;
        start   = cyc;
        lat     = -1;
        ack_cyc = -1;
        rd      = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == drop_at) ifa.enable_i = 1'b0;
            if (ifa.ack_o) begin
                ack_cyc = cyc;
                lat     = cyc - start - 1;
                rd      = ifa.data_o;
                break;
            end
        end
        ifa.enable_i = 1'b0;
        @(negedge clk);
        ack_next = ifa.ack_o;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (ifa.ack_o !== 1'b0 || ifa.data_o !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: ack=%b data=%h expected ack=0 data=0", i, ifa.ack_o, ifa.data_o);
            end
        end
    endtask

    task automatic test_read;
        int lat, ac;
        logic [255:0] rd;
        logic nx;
        do_req(1'b0, 32'h0000, '0, -1, lat, ac, rd, nx);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL read_latency: got %0d expected 10", lat); end
        checks++;
        if (rd !== 256'h5) begin errors++; $display("FAIL read_data: got %h expected 5", rd); end
        checks++;
        if (nx !== 1'b0) begin errors++; $display("FAIL read_ack_width: ack still %b next cycle, expected 0", nx); end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, a1, a2;
        logic [255:0] rd1, rd2;
        logic n1, n2;
        do_req(1'b1, 32'h0400, 256'hDEAD_BEEF, -1, lat1, a1, rd1, n1);
        checks++;
        if (lat1 !== 10) begin errors++; $display("FAIL wr_latency: got %0d expected 10", lat1); end
        checks++;
        if (ifa.data_o !== 256'h5) begin errors++; $display("FAIL wr_keeps_data_o: got %h expected 5", ifa.data_o); end
        do_req(1'b0, 32'h0400, '0, -1, lat2, a2, rd2, n2);
        checks++;
        if (rd2 !== 256'hDEAD_BEEF) begin errors++; $display("FAIL raw_data: got %h expected deadbeef", rd2); end
        checks++;
        if (a2 - a1 !== 12) begin errors++; $display("FAIL ack_spacing: got %0d expected 12", a2 - a1); end
        checks++;
        if (dut_a.u_sram.memory[32] !== 256'hDEAD_BEEF) begin
            errors++; $display("FAIL mem32: got %h expected deadbeef", dut_a.u_sram.memory[32]);
        end
        checks++;
        if (n2 !== 1'b0) begin errors++; $display("FAIL raw_ack_width: ack still %b next cycle, expected 0", n2); end
    endtask

    task automatic test_drop_enable;
        int lat, ac;
        logic [255:0] rd;
        logic nx;
        do_req(1'b1, 32'h0020, 256'h1, 2, lat, ac, rd, nx);
        checks++;
        if (lat !== 10) begin errors++; $display("FAIL drop_latency: got %0d expected 10", lat); end
        checks++;
        if (dut_a.u_sram.memory[1] !== 256'h1) begin
            errors++; $display("FAIL drop_mem1: got %h expected 1", dut_a.u_sram.memory[1]);
        end
    endtask

    task automatic test_reset_mid_request;
        int lat, ac;
        logic [255:0] rd;
        logic nx, got, seen;
        ifa.enable_i = 1'b1; ifa.write_i = 1'b1; ifa.addr_i = 32'h0040; ifa.data_i = 256'hFF;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        ifa.enable_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            seen |= ifa.ack_o;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_no_ack: saw ack=%b expected 0", seen); end
        checks++;
        if (dut_a.u_sram.memory[2] !== 256'hAA) begin
            errors++; $display("FAIL rst_wait_mem2: got %h expected aa", dut_a.u_sram.memory[2]);
        end
        ifa.enable_i = 1'b1; ifa.write_i = 1'b1; ifa.addr_i = 32'h0040; ifa.data_i = 256'hFF;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ifa.ack_o;
        end
        rst_n = 1'b0;
        ifa.enable_i = 1'b0;
        #1;
        checks++;
        if (got !== 1'b1 || ifa.ack_o !== 1'b0) begin
            errors++; $display("FAIL rst_ack_drop: reached_ack=%b ack=%b expected 1 and 0", got, ifa.ack_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_a.u_sram.memory[2] !== 256'hAA) begin
            errors++; $display("FAIL rst_ack_mem2: got %h expected aa", dut_a.u_sram.memory[2]);
        end
        do_req(1'b0, 32'h0040, '0, -1, lat, ac, rd, nx);
        checks++;
        if (lat !== 10 || rd !== 256'hAA) begin
            errors++; $display("FAIL rst_recover_read: lat=%0d data=%h expected 10 and aa", lat, rd);
        end
    endtask

    task automatic test_latency_one;
        int start, lat;
        logic [255:0] rd;
        logic nx;
        ifb.enable_i = 1'b1; ifb.write_i = 1'b0; ifb.addr_i = 32'h4000; ifb.data_i = '0;
        start = cyc;
        lat = -1;
        rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.ack_o) begin lat = cyc - start - 1; rd = ifb.data_o; break; end
        end
        ifb.enable_i = 1'b0;
        @(negedge clk);
        nx = ifb.ack_o;
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL lat1_latency: got %0d expected 1", lat); end
        checks++;
        if (rd !== 256'h77) begin errors++; $display("FAIL lat1_alias_data: got %h expected 77", rd); end
        checks++;
        if (nx !== 1'b0) begin errors++; $display("FAIL lat1_ack_width: ack still %b next cycle, expected 0", nx); end
    endtask

    initial begin
        ifa.enable_i = 1'b0; ifa.write_i = 1'b0; ifa.addr_i = '0; ifa.data_i = '0;
        ifb.enable_i = 1'b0; ifb.write_i = 1'b0; ifb.addr_i = '0; ifb.data_i = '0;
        dut_a.u_sram.memory[0] = 256'h5;
        dut_a.u_sram.memory[2] = 256'hAA;
        dut_b.u_sram.memory[0] = 256'h77;
        @(negedge clk);
        test_reset();
        test_read();
        test_back_to_back();
        test_drop_enable();
        test_reset_mid_request();
        test_latency_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_mem_responder.md
# line_mem_responder

Memory-side responder for the data cache's line-refill/write-back interface. It accepts one 256-bit line request at a time from the cache controller, models a fixed off-chip access latency with a countdown, then completes the request with a one-cycle `ack_o` pulse. It returns read data or commits write data at that point. It sits below `dcache` at the CPU boundary and serves as the synthesizable main-memory model for the system bench.

## Interface
Parameters:
- `DATA_W`, 256, line width in bits.
- `ADDR_W`, 32, request address width.
- `DEPTH`, 512, number of lines (16 KB at 256-bit lines).
- `LATENCY`, 10, cycles from request capture to ack. Legal range is 1..255.

Ports:
- `clk_i`  in  1  single clock, rising-edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  request valid; held high with addr/data/write stable until ack.
- `write_i`  in  1  1 = line write, 0 = line read.
- `addr_i`  in  ADDR_W  byte address. Bits [4:0] are ignored; line index = addr_i[5+$clog2(DEPTH)-1:5].
- `data_i`  in  DATA_W  write line.
- `ack_o`  out  1  one-cycle completion pulse.
- `data_o`  out  DATA_W  read line, valid while `ack_o`=1.

## Operation
- FSM states:
  - IDLE: `ack_o`=0. Transitions to WAIT at a rising edge where `enable_i`=1.
  - WAIT: counts down. Transitions to ACK when the counter reaches 0.
  - ACK: `ack_o`=1 for exactly one cycle. Always transitions to IDLE.
- At the capture edge (IDLE with `enable_i`=1), the block latches the line index, `write_i` and `data_i` into a request register and loads the counter with LATENCY-1.
  - With LATENCY=1 the counter loads 0, WAIT lasts one cycle, and the FSM enters ACK next.
- Inputs are ignored outside IDLE. Dropping `enable_i` mid-WAIT does not cancel the request; it completes with the captured values.
- Read: the array is read with the captured index on the edge entering ACK. `data_o` is registered and holds the value until the next read completes.
- Write: the captured line is committed to the array at the edge leaving ACK. `data_o` is unchanged by a write.
- Back-to-back requests are legal:
  - If `enable_i`=1 in the IDLE cycle after ACK, a new request is captured at that edge.
  - This covers the cache's write-back-then-refill sequence.
  - The minimum request-to-request spacing is LATENCY+2 cycles.
- Read-after-write to the same line returns the new data, because the write commits before the next capture.
- Addresses whose line index exceeds DEPTH-1 alias modulo DEPTH. No error is signalled.
- The array is not cleared by reset. The bench preloads it hierarchically through the instance array named `memory`.

## Timing
- Reset values: state=IDLE, counter=0, `ack_o`=0, `data_o`=0, request register=0.
- Reset asserted mid-WAIT or mid-ACK:
  - The pending request is dropped and any pending write is not committed.
  - `ack_o` drops immediately, since reset is asynchronous.
- Latency: capture at edge E0 puts `ack_o` high during the cycle between edges E0+LATENCY and E0+LATENCY+1.
- `ack_o` is never high for two consecutive cycles.
- The counter is 8 bits wide, decrements only in WAIT, and never wraps, because WAIT exits at 0.

## Structure
- Shared package `mem_if_pkg` holds:
  - `LINE_W`=256, `LINE_OFFSET_W`=5.
  - State enum `mem_state_e` {IDLE, WAIT, ACK}.
- Sub-module `line_sram`:
  - DEPTH x DATA_W array named `memory`.
  - Synchronous write enable and registered read.
  - Instantiated once; the FSM, counter and request register live in the top.

## Test plan
- Reset then idle: `ack_o`=0 and `data_o`=0 for 20 cycles with `enable_i`=0.
- Preload `memory[0]`=256'h5, read addr 0x0000 with LATENCY=10: `ack_o` rises exactly 10 cycles after capture for one cycle, with `data_o`=256'h5.
- Write 0x0400 with data 256'hDEAD_BEEF, then read 0x0400 back-to-back: the second ack returns 256'hDEAD_BEEF and `memory[32]` holds it. Ack spacing is 12 cycles.
- Drop `enable_i` two cycles after capturing a write to 0x0020 with 256'h1: the ack still occurs at the LATENCY edge and `memory[1]`=256'h1.
- Assert `rst_i`=0 during WAIT of a write to 0x0040 with 256'hFF:
  - No ack occurs and `memory[2]` is unchanged.
  - After release, a new read request completes normally.
- LATENCY=1 and address 0x4000 (aliases to line 0): ack occurs in the cycle after capture and returns `memory[0]`.
